delay_sequencer: RTL and testbench
==================================

DELAY_SEQUENCER -- requirements
Module: delay_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning the width of the output value.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each step delay in clock cycles.
REQ-003 SHALL have parameter DEPTH, default 8, meaning the number of step-table entries (power of 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1, which writes one step-table entry.
REQ-007 SHALL have port wr_addr, input, log2(DEPTH), the entry index.
REQ-008 SHALL have port wr_delay, input, CNT_W, the step delay in cycles.
REQ-009 SHALL have port wr_value, input, DATA_W, the step output value.
REQ-010 SHALL have port num_steps, input, log2(DEPTH)+1, the step count, sampled at start.
REQ-011 SHALL have port loop_en, input, 1, which restarts at step 0 after the last step; sampled at start.
REQ-012 SHALL have port start, input, 1, a single-cycle run request.
REQ-013 SHALL have port abort, input, 1, which stops the run.
REQ-014 SHALL have port a, output, DATA_W, the registered sequenced value.
REQ-015 SHALL have port busy, output, 1, which is high while a run is active.
REQ-016 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-017 SHALL have port step_idx, output, log2(DEPTH), the index of the step currently counting.

Function
REQ-018 SHALL implement states IDLE, RUN, LAST.
- IDLE->RUN: start=1, num_steps in 1..DEPTH.
- RUN->IDLE: final step applied with loop_en=0.
- Any->IDLE: abort.
REQ-019 SHALL ignore start when num_steps=0 or num_steps>DEPTH; the block stays in IDLE and a does not change.
REQ-020 SHALL make step k's value appear on a at cycle t0+sum(i=0..k) max(d_i,1), where t0 is the start edge; a delay of 0 counts as 1.
REQ-021 SHALL hold a between steps and after the run ends; a changes only on a step expiry.
REQ-022 SHALL assert busy from the cycle after start through the cycle the final value appears, inclusive.
REQ-023 SHALL pulse done for exactly one cycle, coincident with the final value appearing on a; no done pulse on abort.
REQ-024 SHALL, with loop_en=1, load step 0 in the cycle after the last step expires, with no gap; busy stays high and done pulses once per pass.
REQ-025 SHALL accept writes only in IDLE; writes while busy SHALL be dropped.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL give abort priority over a simultaneous start or step expiry: a holds its current value and busy drops on the next edge.
REQ-028 SHALL wrap step_idx to 0 after DEPTH-1.

Reset
REQ-029 SHALL, on rst, asynchronously clear a, busy, done, step_idx, the counter, and the state (to IDLE).
REQ-030 SHALL not clear step-table contents on rst.
REQ-031 SHALL, on rst mid-run, end the run with no done pulse; a new start is needed after rst deasserts.

Structure
REQ-032 SHALL place the state encoding and the default widths in the shared package delay_seq_pkg.
REQ-033 SHALL implement the per-step down-counter as sub-module delay_seq_timer, with inputs load, load_val, en and output expire.
REQ-034 SHALL hold the step table as a register array inside delay_sequencer, with one write port and one read port.

Verification
REQ-035 Program delays {5,6,2,9,1} and values {6,5,1,0,5}, num_steps=5, start at cycle 0 -> a = 6@5, 5@11, 1@13, 0@22, 5@23; done only @23; busy cycles 1..23.
REQ-036 Step delay 0, value 3, num_steps=1 -> a=3 and done one cycle after start.
REQ-037 loop_en=1 with 2 steps, delays {2,3}, values {1,2} -> a = 1@2, 2@5, 1@7, 2@10; done @5 and @10.
REQ-038 abort at cycle 12 during the REQ-035 run -> a holds 5, busy=0 from 13, no done, step 2 never applied.
REQ-039 wr_en during a run writing value F to entry 0 -> entry 0 unchanged on the next run; start while busy has no effect; num_steps=0 start -> stays IDLE.
REQ-040 rst asserted at cycle 8 of a run -> a=0, busy=0 immediately; the table is intact, so a rerun reproduces REQ-035 timing.

Source files
------------

// File: rtl/delay_seq_pkg.sv
// Shared definitions for the delay sequencer: default widths and the
// sequencer state encoding.
package delay_seq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } seq_state_e;

endpackage

// File: rtl/delay_seq_timer.sv
// Per-step down-counter: expire is high while enabled and the step has one
// cycle (or fewer) left to run.
module delay_seq_timer
  import delay_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  assign expire = en && (cnt_r <= CNT_ONE);

  // Count register: a load always wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

endmodule

// File: rtl/delay_sequencer.sv
// Table-driven delay sequencer: steps through programmed {delay, value}
// entries, updating output a as each step's delay expires.
module delay_sequencer
  import delay_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [CNT_W-1:0]           wr_delay,
  input  logic [DATA_W-1:0]          wr_value,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       abort,
  output logic [DATA_W-1:0]          a,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]    NUM_ZERO  = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]    NUM_ONE   = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0]    NUM_MAX   = (IDX_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef struct packed {
    logic [CNT_W-1:0]  dly;
    logic [DATA_W-1:0] val;
  } entry_t;

  function automatic logic [CNT_W-1:0] eff_dly(input logic [CNT_W-1:0] d);
    return (d == CNT_ZERO) ? CNT_ONE : d;
  endfunction

  seq_state_e        state_r;
  entry_t            tbl_r [DEPTH];
  entry_t            head_r;
  entry_t            rd_entry_s;
  entry_t            wr_entry_s;
  logic [IDX_W-1:0]  rd_addr_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  nxt_idx_s;
  logic [IDX_W:0]    num_r;
  logic [IDX_W:0]    num_m1_s;
  logic              loop_r;
  logic [DATA_W-1:0] cur_val_r;
  logic [DATA_W-1:0] a_r;
  logic              busy_r;
  logic              done_r;
  logic              wr_ok_s;
  logic              start_ok_s;
  logic              start_single_s;
  logic              head_short_s;
  logic [CNT_W-1:0]  head_dly_s;
  logic              is_last_s;
  logic              fire_s;
  logic              tmr_load_s;
  logic [CNT_W-1:0]  tmr_val_s;
  logic              tmr_en_s;

  assign a        = a_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign step_idx = idx_r;

  assign wr_ok_s        = wr_en && (state_r == IDLE);
  assign wr_entry_s     = '{dly: wr_delay, val: wr_value};
  assign start_ok_s     = start && (num_steps != NUM_ZERO) && (num_steps <= NUM_MAX);
  assign start_single_s = (num_steps == NUM_ONE);
  assign head_dly_s     = eff_dly(head_r.dly);
  assign head_short_s   = (head_dly_s == CNT_ONE);
  assign num_m1_s       = num_r - NUM_ONE;
  assign is_last_s      = (idx_r == num_m1_s[IDX_W-1:0]);
  assign nxt_idx_s      = is_last_s ? IDX_ZERO : idx_r + IDX_ONE;
  assign rd_entry_s     = tbl_r[rd_addr_s];
  assign tmr_en_s       = (state_r == RUN);

  // Single read port: entry 0 is mirrored while idle, entry 1 is read on the
  // start edge, and the following step is read while running.
  always_comb begin
    rd_addr_s = IDX_ZERO;
    case (state_r)
      IDLE:    rd_addr_s = start ? IDX_ONE : IDX_ZERO;
      RUN:     rd_addr_s = nxt_idx_s;
      default: rd_addr_s = IDX_ZERO;
    endcase
  end

  // Step table storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      tbl_r[wr_addr] <= wr_entry_s;
    end
  end

  // Mirror of entry 0 so a start can apply step 0 and fetch step 1 together.
  always_ff @(posedge clk) begin
    if ((state_r == IDLE) && !start) begin
      head_r <= (wr_ok_s && (wr_addr == IDX_ZERO)) ? wr_entry_s : rd_entry_s;
    end
  end

  // Timer reload: step 0 is one cycle shorter because its first cycle is the start edge.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = CNT_ZERO;
    case (state_r)
      IDLE: begin
        if (!abort && start_ok_s) begin
          tmr_load_s = 1'b1;
          if (head_short_s) begin
            tmr_val_s = start_single_s ? CNT_ONE : eff_dly(rd_entry_s.dly);
          end else begin
            tmr_val_s = head_dly_s - CNT_ONE;
          end
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      RUN: begin
        if (!abort && fire_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = eff_dly(rd_entry_s.dly);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  delay_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .expire   (fire_s)
  );

  // Sequencer FSM with registered outputs; abort outranks start and expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= DATA_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      idx_r     <= IDX_ZERO;
      num_r     <= NUM_ZERO;
      loop_r    <= 1'b0;
      cur_val_r <= DATA_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          if (!abort && start_ok_s) begin
            num_r     <= num_steps;
            loop_r    <= loop_en;
            busy_r    <= 1'b1;
            idx_r     <= IDX_ZERO;
            state_r   <= RUN;
            cur_val_r <= head_r.val;
            if (head_short_s) begin
              a_r <= head_r.val;
              if (start_single_s) begin
                done_r <= 1'b1;
                if (!loop_en) begin
                  state_r <= LAST;
                end
              end else begin
                idx_r     <= IDX_ONE;
                cur_val_r <= rd_entry_s.val;
              end
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (fire_s) begin
            a_r <= cur_val_r;
            if (is_last_s) begin
              done_r <= 1'b1;
              if (loop_r) begin
                idx_r     <= nxt_idx_s;
                cur_val_r <= rd_entry_s.val;
              end else begin
                state_r <= LAST;
              end
            end else begin
              idx_r     <= nxt_idx_s;
              cur_val_r <= rd_entry_s.val;
            end
          end
        end
        LAST: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sequencer.sv
// Directed bench for delay_sequencer: cycle k is observed on the falling edge
// before rising edge k, where rising edge 0 samples start.
module tb_delay_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_delay;
  logic [3:0] wr_value;
  logic [3:0] num_steps;
  logic       loop_en;
  logic       start;
  logic       abort;
  logic [3:0] a;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int cyc;
    bit ab;
    bit pk;
    int a;
    int busy;
    int done;
    bit ci;
    int idx;
  } rec_t;

  rec_t recs[$];

  delay_sequencer #(.DATA_W(4), .CNT_W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_delay  (wr_delay),
    .wr_value  (wr_value),
    .num_steps (num_steps),
    .loop_en   (loop_en),
    .start     (start),
    .abort     (abort),
    .a         (a),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input int cyc, input int ab, input int pk, input int ea,
                     input int eb, input int ed, input int ci, input int idx);
    rec_t r;
    r.cyc = cyc; r.ab = ab[0]; r.pk = pk[0]; r.a = ea; r.busy = eb;
    r.done = ed; r.ci = ci[0]; r.idx = idx;
    recs.push_back(r);
  endtask

  task automatic wr_entry(input int addr, input int d, input int v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr[2:0]; wr_delay = d[7:0]; wr_value = v[3:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cmp_rec(input string tag, input int k, input rec_t r);
    check($sformatf("%s c%0d a", tag, k), int'(a), r.a);
    check($sformatf("%s c%0d busy", tag, k), int'(busy), r.busy);
    check($sformatf("%s c%0d done", tag, k), int'(done), r.done);
    if (r.ci) check($sformatf("%s c%0d step_idx", tag, k), int'(step_idx), r.idx);
  endtask

  // Expectations hold from a record's cycle until the next record; abort and
  // poke inputs apply only in the record's own cycle.
  task automatic run_trace(input string tag, input int last_cyc,
                           input logic [3:0] ns, input logic lp);
    int   j;
    rec_t cur;
    @(negedge clk);
    abort = 1'b0; wr_en = 1'b0;
    num_steps = ns; loop_en = lp; start = 1'b1;
    j = 0;
    cur = recs[0];
    cmp_rec(tag, 0, cur);
    for (int k = 1; k <= last_cyc; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; wr_en = 1'b0;
      if ((j + 1 < recs.size()) && (recs[j+1].cyc == k)) begin
        j++;
        cur = recs[j];
        if (cur.ab) abort = 1'b1;
        if (cur.pk) begin
          wr_en = 1'b1; wr_addr = 3'd0; wr_delay = 8'd1; wr_value = 4'hF;
          start = 1'b1;
        end
      end
      cmp_rec(tag, k, cur);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    recs.delete();
  endtask

  task automatic main_recs(input int a0, input bit poke);
    add(0, 0, 0, a0, 0, 0, 0, 0);
    add(1, 0, 0, a0, 1, 0, 1, 0);
    if (poke) add(3, 0, 1, a0, 1, 0, 1, 0);
    add(5, 0, 0, 6, 1, 0, 1, 1);
    add(11, 0, 0, 5, 1, 0, 1, 2);
    add(13, 0, 0, 1, 1, 0, 1, 3);
    add(22, 0, 0, 0, 1, 0, 1, 4);
    add(23, 0, 0, 5, 1, 1, 0, 0);
    add(24, 0, 0, 5, 0, 0, 0, 0);
  endtask

  task automatic ignored_start(input logic [3:0] ns);
    @(negedge clk);
    num_steps = ns; loop_en = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("bad_num%0d c%0d busy", ns, k), int'(busy), 0);
      check($sformatf("bad_num%0d c%0d a", ns, k), int'(a), 5);
      check($sformatf("bad_num%0d c%0d done", ns, k), int'(done), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_delay = 8'd0; wr_value = 4'd0;
    num_steps = 4'd0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset a", int'(a), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset step_idx", int'(step_idx), 0);

    wr_entry(0, 5, 6);
    wr_entry(1, 6, 5);
    wr_entry(2, 2, 1);
    wr_entry(3, 9, 0);
    wr_entry(4, 1, 5);

    main_recs(0, 1'b0);
    run_trace("main", 26, 4'd5, 1'b0);

    add(0, 0, 0, 5, 0, 0, 0, 0);
    add(1, 0, 0, 5, 1, 0, 1, 0);
    add(5, 0, 0, 6, 1, 0, 1, 1);
    add(11, 0, 0, 5, 1, 0, 1, 2);
    add(12, 1, 0, 5, 1, 0, 1, 2);
    add(13, 0, 0, 5, 0, 0, 0, 0);
    run_trace("abort", 20, 4'd5, 1'b0);

    main_recs(5, 1'b1);
    run_trace("busy_poke", 26, 4'd5, 1'b0);

    ignored_start(4'd0);
    ignored_start(4'd9);

    // Reset in the middle of a run, then rerun on the retained table.
    @(negedge clk);
    num_steps = 4'd5; loop_en = 1'b0; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 7) begin
        check("pre_rst busy", int'(busy), 1);
        check("pre_rst a", int'(a), 6);
      end
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst a", int'(a), 0);
    check("mid_rst busy", int'(busy), 0);
    check("mid_rst done", int'(done), 0);
    check("mid_rst step_idx", int'(step_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst busy", int'(busy), 0);

    main_recs(0, 1'b0);
    run_trace("rerun", 26, 4'd5, 1'b0);

    wr_entry(0, 0, 3);
    add(0, 0, 0, 5, 0, 0, 0, 0);
    add(1, 0, 0, 3, 1, 1, 0, 0);
    add(2, 0, 0, 3, 0, 0, 0, 0);
    run_trace("zero_dly", 4, 4'd1, 1'b0);

    wr_entry(0, 2, 1);
    wr_entry(1, 3, 2);
    add(0, 0, 0, 3, 0, 0, 0, 0);
    add(1, 0, 0, 3, 1, 0, 1, 0);
    add(2, 0, 0, 1, 1, 0, 1, 1);
    add(5, 0, 0, 2, 1, 1, 1, 0);
    add(6, 0, 0, 2, 1, 0, 1, 0);
    add(7, 0, 0, 1, 1, 0, 1, 1);
    add(10, 0, 0, 2, 1, 1, 1, 0);
    add(11, 0, 0, 2, 1, 0, 1, 0);
    add(12, 1, 0, 1, 1, 0, 1, 1);
    add(13, 0, 0, 1, 0, 0, 0, 0);
    run_trace("loop", 15, 4'd2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
